// File: rtl/param_updown_counter.sv
// Parametrised loadable up/down counter with wrap or saturate mode.
// Ports: clk, rst (async high), load/in, en, up_dn -> c, tc, ovf, udf.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP    = 1,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH:0] MAX_E =
    (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_E =
    (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_W =
    WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_W =
    WIDTH'(STEP);
  // Modulus may be 2**WIDTH and truncate
  // to zero; the wrap sums stay correct
  // modulo 2**WIDTH because every wrapped
  // result lies below the modulus.
  localparam logic [WIDTH-1:0] MOD_W =
    WIDTH'(MAX_VAL+1);

  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH:0]   c_e;
  logic [WIDTH:0]   in_e;
  logic [WIDTH:0]   sum_e;
  logic             up_over;
  logic             dn_under;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] ld_next;

  always_comb begin
    c_e      = {1'b0, c_q};
    in_e     = {1'b0, in};
    sum_e    = c_e + STEP_E;
    up_over  = sum_e > MAX_E;
    dn_under = c_e < STEP_E;
    ld_next  = (in_e > MAX_E) ? MAX_W : in;

    up_next = c_q + STEP_W;
    if (up_over) begin
      if (SAT != 0) up_next = MAX_W;
      else up_next = c_q + STEP_W - MOD_W;
    end

    dn_next = c_q - STEP_W;
    if (dn_under) begin
      if (SAT != 0) dn_next = '0;
      else dn_next = c_q + MOD_W - STEP_W;
    end
  end

  always_comb begin
    c_d   = c_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (load) begin
      c_d = ld_next;
    end else if (en) begin
      if (up_dn) begin
        c_d   = up_next;
        ovf_d = up_over;
      end else begin
        c_d   = dn_next;
        udf_d = dn_under;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Look-ahead: next enabled edge leaves range.
  assign tc  = en & ((up_dn & (c_e > MAX_E - STEP_E))
                   | (~up_dn & dn_under));
  assign c   = c_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule
